tpm_wb_regs: RTL and testbench
==============================

# tpm_wb_regs

Wishbone slave for the TPM ↔ SoC communication register window at 0xF0000000. It sits between the CPU Wishbone bus and the LPC-side TPM register block.
- Brings the LPC-domain exec/abort flags into the CPU clock domain through synchronizers.
- Snapshots the command descriptors (op type, locality, buffer length) when a command starts.
- Raises a maskable interrupt on command start and on abort.
- Generates the fixed-width `complete` pulse back to the LPC side when firmware writes the COMPLETE register.

## Interface
Parameters
- `ADDR_WIDTH`, 11: Wishbone address bits decoded inside the window.
- `BUF_LEN_WIDTH`, 11: width of `buf_len_i`.
- `COMPLETE_PULSE_WIDTH`, 20: `complete_o` high time in clocks; legal range 1..255.
- `DEFAULT_READ_VALUE`, 32'hBADFABAC: read data for unmapped offsets.

Ports
- `clk_i` in 1: Wishbone/CPU clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `wb_adr_i` in `ADDR_WIDTH`: byte address within the window.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered.
- `wb_we_i` in 1: write enable.
- `wb_sel_i` in 4: byte enables.
- `wb_stb_i` in 1: strobe; already qualified by the top-level window decode.
- `wb_cyc_i` in 1: cycle valid.
- `wb_ack_o` out 1: transfer acknowledge.
- `wb_err_o` out 1: transfer error; tied 0.
- `exec_i` in 1: command-pending flag, LPC domain, asynchronous.
- `abort_i` in 1: abort flag, LPC domain, asynchronous.
- `op_type_i` in 4: operation type, quasi-static while `exec_i` is high.
- `locality_i` in 4: locality, quasi-static while `exec_i` is high.
- `buf_len_i` in `BUF_LEN_WIDTH`: command length, quasi-static while `exec_i` is high.
- `complete_o` out 1: completion pulse to the LPC register block.
- `irq_o` out 1: CPU external interrupt, level.

## Operation
- **Synchronizers.** `exec_i` and `abort_i` each pass through 2 flops to give `exec_s` / `abort_s`. A third flop per signal holds the previous value for rising-edge detection.
- **Snapshot.** On the `exec_s` rising edge, capture `op_type_i`, `locality_i`, `buf_len_i` into shadow registers. The shadows hold until the next rising edge.
- **Register map** (word-decoded on `wb_adr_i[ADDR_WIDTH-1:2]`):
  - 0x00 STATUS, RO: `{29'b0, complete_o, abort_s, exec_s}`.
  - 0x04 OP_TYPE, RO: `{28'b0, shadow op_type}`.
  - 0x08 LOCALITY, RO: `{28'b0, shadow locality}`.
  - 0x0C BUF_SIZE, RO: shadow `buf_len`, zero-extended.
  - 0x10 IRQ_PEND, W1C: bit0 = exec rise, bit1 = abort rise. A write applies only when `wb_sel_i[0]`=1.
  - 0x14 IRQ_EN, RW: bits [1:0]. A write applies only when `wb_sel_i[0]`=1.
  - 0x40 COMPLETE, WO, reads 0. A write with any `wb_sel_i`≠0 loads the pulse counter with `COMPLETE_PULSE_WIDTH`, only when the counter is 0 and `exec_s`=1. Otherwise the write is silently ignored.
  - Any other offset: reads return `DEFAULT_READ_VALUE`; writes are ignored and still acked.
- **Pulse counter.** 8-bit; decrements to 0 every clock while nonzero. `complete_o` = (counter ≠ 0), driven from a register.
- **Interrupt.** `irq_o` = |(IRQ_PEND & IRQ_EN[1:0]).
- **Set/clear conflict.** If an edge-set and a W1C clear hit the same IRQ_PEND bit in the same cycle, the set wins.
- **Reset values.** All outputs 0: `wb_dat_o`, `wb_ack_o`, `complete_o`, `irq_o`. All internal registers 0: shadows, IRQ_PEND, IRQ_EN, counter, synchronizers.
- **Reset mid-pulse.** `complete_o` drops asynchronously and the counter clears.

## Timing
- **Ack.** `wb_ack_o` <= `wb_cyc_i & wb_stb_i & ~wb_ack_o` on each rising edge. This gives one wait state and a single-cycle ack; back-to-back requests ack every other cycle.
- **Read data.** `wb_dat_o` is registered on the same edge that sets `wb_ack_o` and is valid while ack is high. Otherwise it holds 0.
- **Write commit.** Writes commit on the edge that asserts `wb_ack_o`; each transfer commits exactly once.
- **Command-start latency.** `exec_i` rises asynchronously before edge N. Then `exec_s` is high after edge N+1. On edge N+2 the shadows are captured and IRQ_PEND[0] is set. `irq_o` is high after edge N+2 if enabled.
- **Abort latency.** Same N+2 latency for `abort_i` → IRQ_PEND[1].
- **Complete pulse.** An accepted COMPLETE write on edge W makes `complete_o` high from after edge W through exactly `COMPLETE_PULSE_WIDTH` clocks.
- **Complete retrigger.** A second COMPLETE write while the pulse is active has no effect and does not extend the pulse.
- **Exec fall mid-pulse.** If `exec_s` falls during the pulse, the pulse still runs to full length.

## Test plan
- **Reset.** Assert `rstn_i`=0 mid-transfer → all outputs 0. Read STATUS after release → 0x00000000, with ack exactly 1 cycle after stb.
- **Command start and snapshot.** Enable IRQ_EN=0x1. Drive `op_type_i`=4'h3, `locality_i`=4'h2, `buf_len_i`=11'h1A0, then raise `exec_i`.
  - `irq_o` goes high 2 edges after the sampling edge.
  - Reads return OP_TYPE=0x3, LOCALITY=0x2, BUF_SIZE=0x1A0, STATUS=0x1.
  - Writing 0x1 to IRQ_PEND drops `irq_o`.
- **Complete pulse.** With `exec_s`=1, write COMPLETE → `complete_o` high for exactly 20 clocks and STATUS bit2=1 during the pulse. A second write at clock 5 does not extend the pulse.
- **Complete gating.** With `exec_s`=0, write COMPLETE → `complete_o` stays 0.
- **W1C conflict.** Write 0x2 to IRQ_PEND on the same edge as the `abort_s` rising edge → IRQ_PEND[1] remains 1.
- **Unmapped and byte enables.** Read offset 0x20 → 0xBADFABAC with ack. Write IRQ_EN with `wb_sel_i`=4'b0010 → IRQ_EN unchanged.

Source files
------------

// File: rtl/tpm_wb_regs.sv
// TPM <-> SoC Wishbone register window.
// Syncs LPC exec/abort, snapshots descriptors, drives irq and complete pulse.
module tpm_wb_regs #(
  parameter int          ADDR_WIDTH           = 11,
  parameter int          BUF_LEN_WIDTH        = 11,
  parameter int          COMPLETE_PULSE_WIDTH = 20,
  parameter logic [31:0] DEFAULT_READ_VALUE   = 32'hBADFABAC
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [ADDR_WIDTH-1:0]    wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  output logic [31:0]              wb_dat_o,
  input  logic                     wb_we_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  input  logic                     exec_i,
  input  logic                     abort_i,
  input  logic [3:0]               op_type_i,
  input  logic [3:0]               locality_i,
  input  logic [BUF_LEN_WIDTH-1:0] buf_len_i,
  output logic                     complete_o,
  output logic                     irq_o
);

  localparam int AW = ADDR_WIDTH - 2;
  typedef logic [AW-1:0] idx_t;

  localparam idx_t R_STATUS   = idx_t'(0);
  localparam idx_t R_OP_TYPE  = idx_t'(1);
  localparam idx_t R_LOCALITY = idx_t'(2);
  localparam idx_t R_BUF_SIZE = idx_t'(3);
  localparam idx_t R_IRQ_PEND = idx_t'(4);
  localparam idx_t R_IRQ_EN   = idx_t'(5);
  localparam idx_t R_COMPLETE = idx_t'(16);

  logic exec_meta, exec_s, exec_q;
  logic abort_meta, abort_s, abort_q;
  logic exec_rise, abort_rise;

  logic [3:0]               sh_op;
  logic [3:0]               sh_loc;
  logic [BUF_LEN_WIDTH-1:0] sh_len;
  logic [1:0]               pend, pend_clr, pend_nxt;
  logic [1:0]               en;
  logic [7:0]               cnt, cnt_nxt;

  idx_t        idx;
  logic        req, wr, rd, cmp_go;
  logic [31:0] rdata;
  logic        unused_bits;

  assign idx        = wb_adr_i[ADDR_WIDTH-1:2];
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = req & wb_we_i;
  assign rd         = req & ~wb_we_i;
  assign exec_rise  = exec_s & ~exec_q;
  assign abort_rise = abort_s & ~abort_q;
  assign wb_err_o   = 1'b0;
  assign irq_o      = |(pend & en);
  assign unused_bits = ^{wb_dat_i[31:2], wb_adr_i[1:0]};

  always_comb begin
    rdata = DEFAULT_READ_VALUE;
    case (idx)
      R_STATUS:   rdata = {29'b0, complete_o, abort_s, exec_s};
      R_OP_TYPE:  rdata = {28'b0, sh_op};
      R_LOCALITY: rdata = {28'b0, sh_loc};
      R_BUF_SIZE: rdata = {{(32-BUF_LEN_WIDTH){1'b0}}, sh_len};
      R_IRQ_PEND: rdata = {30'b0, pend};
      R_IRQ_EN:   rdata = {30'b0, en};
      R_COMPLETE: rdata = 32'b0;
      default:    rdata = DEFAULT_READ_VALUE;
    endcase
  end

  // Edge-set is OR-ed in after the W1C clear so a same-cycle set wins.
  always_comb begin
    pend_clr = 2'b0;
    if (wr && idx == R_IRQ_PEND && wb_sel_i[0])
      pend_clr = wb_dat_i[1:0];
    pend_nxt = (pend & ~pend_clr) | {abort_rise, exec_rise};
  end

  // Retrigger while running or without a pending command is dropped.
  always_comb begin
    cmp_go = wr && idx == R_COMPLETE && (|wb_sel_i)
             && cnt == 8'd0 && exec_s;
    if (cmp_go)
      cnt_nxt = 8'(COMPLETE_PULSE_WIDTH);
    else if (cnt != 8'd0)
      cnt_nxt = cnt - 8'd1;
    else
      cnt_nxt = 8'd0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      exec_meta  <= 1'b0;
      exec_s     <= 1'b0;
      exec_q     <= 1'b0;
      abort_meta <= 1'b0;
      abort_s    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      exec_meta  <= exec_i;
      exec_s     <= exec_meta;
      exec_q     <= exec_s;
      abort_meta <= abort_i;
      abort_s    <= abort_meta;
      abort_q    <= abort_s;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sh_op  <= '0;
      sh_loc <= '0;
      sh_len <= '0;
    end else if (exec_rise) begin
      sh_op  <= op_type_i;
      sh_loc <= locality_i;
      sh_len <= buf_len_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend <= 2'b0;
      en   <= 2'b0;
    end else begin
      pend <= pend_nxt;
      if (wr && idx == R_IRQ_EN && wb_sel_i[0])
        en <= wb_dat_i[1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt        <= 8'd0;
      complete_o <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      complete_o <= cnt_nxt != 8'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rdata : 32'b0;
    end
  end

endmodule

// File: tb/tb_tpm_wb_regs.sv
// Scoreboard bench for tpm_wb_regs.
// Stimulus queues expected read data; a negedge monitor checks each ack.
module tb_tpm_wb_regs;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [10:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        exec_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  op_type_i = '0;
  logic [3:0]  locality_i = '0;
  logic [10:0] buf_len_i = '0;
  logic        complete_o;
  logic        irq_o;

  tpm_wb_regs dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .exec_i(exec_i), .abort_i(abort_i), .op_type_i(op_type_i),
    .locality_i(locality_i), .buf_len_i(buf_len_i),
    .complete_o(complete_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        chk;
    logic [31:0] d;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  always @(negedge clk_i) begin
    if (rstn_i && wb_ack_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) check(e.name, wb_dat_o, e.d);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acking edge.
  task automatic xfer(input logic [10:0] adr, input logic we,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input string name, input logic [31:0] expd,
                      output int lat);
    exp_t e;
    e.chk = !we;
    e.d = expd;
    e.name = name;
    exp_q.push_back(e);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk_i); #1;
      lat++;
      if (wb_ack_o) break;
    end
    if (!wb_ack_o) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic rd(input logic [10:0] adr, input logic [31:0] expd,
                    input string name);
    int l;
    xfer(adr, 1'b0, 32'd0, 4'hF, name, expd, l);
  endtask

  task automatic wr(input logic [10:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    int l;
    xfer(adr, 1'b1, dat, sel, "wr", 32'd0, l);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  int lat;
  int hi_cnt;

  initial begin
    // Reset asserted with a transfer in flight
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 11'h000;
    cyc(3);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_complete", {31'b0, complete_o}, 32'd0);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rstn_i = 1'b1;
    cyc(2);

    xfer(11'h000, 1'b0, 32'd0, 4'hF, "status_rst", 32'h0, lat);
    check("ack_latency", 32'(lat), 32'd1);
    check("err_tied", {31'b0, wb_err_o}, 32'd0);

    // Command start and snapshot
    wr(11'h014, 32'h1, 4'hF);
    op_type_i = 4'h3; locality_i = 4'h2; buf_len_i = 11'h1A0;
    exec_i = 1'b1;
    cyc(2);
    check("irq_n1", {31'b0, irq_o}, 32'd0);
    cyc(1);
    check("irq_n2", {31'b0, irq_o}, 32'd1);
    op_type_i = 4'hF; locality_i = 4'hF; buf_len_i = 11'h7FF;
    rd(11'h004, 32'h3, "op_type");
    rd(11'h008, 32'h2, "locality");
    rd(11'h00C, 32'h1A0, "buf_size");
    rd(11'h000, 32'h1, "status_exec");
    rd(11'h010, 32'h1, "pend_exec");
    wr(11'h010, 32'h1, 4'hF);
    check("irq_w1c", {31'b0, irq_o}, 32'd0);
    rd(11'h010, 32'h0, "pend_clr");

    // Complete pulse with a retrigger mid-pulse
    wr(11'h040, 32'h1, 4'hF);
    fork
      begin
        hi_cnt = complete_o ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
          @(posedge clk_i); #1;
          if (!complete_o) break;
          hi_cnt++;
        end
      end
      begin
        cyc(3);
        wr(11'h040, 32'h1, 4'h1);
        rd(11'h000, 32'h5, "status_pulse");
        rd(11'h040, 32'h0, "complete_rd");
      end
    join
    check("pulse_width", 32'(hi_cnt), 32'd20);

    // Complete gated while exec is low
    exec_i = 1'b0;
    cyc(4);
    rd(11'h000, 32'h0, "status_idle");
    wr(11'h040, 32'h1, 4'hF);
    check("gate_c0", {31'b0, complete_o}, 32'd0);
    cyc(2);
    check("gate_c2", {31'b0, complete_o}, 32'd0);

    // Abort rise lands on the same edge as a W1C of bit1
    abort_i = 1'b1;
    cyc(2);
    wr(11'h010, 32'h2, 4'hF);
    rd(11'h010, 32'h2, "pend_conflict");
    check("irq_masked", {31'b0, irq_o}, 32'd0);
    wr(11'h014, 32'h3, 4'hF);
    check("irq_abort", {31'b0, irq_o}, 32'd1);

    // Unmapped offset and byte-enable gating
    rd(11'h020, 32'hBADFABAC, "unmapped");
    wr(11'h014, 32'h0, 4'b0010);
    rd(11'h014, 32'h3, "irq_en_sel");

    // Reset during an active pulse
    exec_i = 1'b1;
    cyc(4);
    wr(11'h040, 32'h1, 4'hF);
    cyc(2);
    check("pulse_on", {31'b0, complete_o}, 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    check("rst_pulse", {31'b0, complete_o}, 32'd0);
    check("rst_irq2", {31'b0, irq_o}, 32'd0);

    cyc(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
